// File: rtl/display_sequencer.sv
// Display-side responder: walks the PE, 3x3 and 2x2 result phases, streams each
// buffer word over a valid/ready handshake, then dwells before moving on.
module display_sequencer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 5,
  parameter int PE_WORDS     = 16,
  parameter int SA3_WORDS    = 9,
  parameter int SA2_WORDS    = 4,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_display,
  input  logic              next_btn,
  output logic              rd_en,
  output logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_last,
  input  logic              disp_ready,
  output logic [2:0]        current_display
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DWELL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] PH_PE   = 3'd1;
  localparam logic [2:0] PH_SA3  = 3'd2;
  localparam logic [2:0] PH_SA2  = 3'd3;
  localparam logic [2:0] PH_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] PE_LAST  = ADDR_W'(PE_WORDS - 1);
  localparam logic [ADDR_W-1:0] SA3_LAST = ADDR_W'(SA3_WORDS - 1);
  localparam logic [ADDR_W-1:0] SA2_LAST = ADDR_W'(SA2_WORDS - 1);
  localparam logic [31:0]       DWELL_LAST = 32'(DWELL_CYCLES - 1);

  logic [2:0]        sub;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       dwell_cnt;
  logic              next_btn_q;
  logic [ADDR_W-1:0] last_idx;
  logic              btn_rise;
  logic              dwell_done;

  always_comb begin
    last_idx = PE_LAST;
    case (current_display)
      PH_SA3:  last_idx = SA3_LAST;
      PH_SA2:  last_idx = SA2_LAST;
      default: last_idx = PE_LAST;
    endcase
  end

  assign btn_rise   = next_btn & ~next_btn_q;
  assign dwell_done = (dwell_cnt == DWELL_LAST) | btn_rise;

  // Button rises outside DWELL are simply dropped; the history register still tracks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_display <= 3'd0;
      sub             <= S_IDLE;
      idx             <= '0;
      dwell_cnt       <= 32'd0;
      next_btn_q      <= 1'b0;
      rd_en           <= 1'b0;
      rd_sel          <= 2'd0;
      rd_addr         <= '0;
      disp_valid      <= 1'b0;
      disp_data       <= '0;
      disp_last       <= 1'b0;
    end else begin
      next_btn_q <= next_btn;
      rd_en      <= 1'b0;
      if (!state_display && sub != S_IDLE) begin
        current_display <= 3'd0;
        sub             <= S_IDLE;
        idx             <= '0;
        dwell_cnt       <= 32'd0;
        disp_valid      <= 1'b0;
        disp_last       <= 1'b0;
      end else begin
        case (sub)
          S_IDLE: begin
            if (state_display) begin
              current_display <= PH_PE;
              sub             <= S_ISSUE;
              idx             <= '0;
              rd_en           <= 1'b1;
              rd_sel          <= 2'd0;
              rd_addr         <= '0;
            end
          end
          S_ISSUE: sub <= S_LATCH;
          S_LATCH: begin
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
            disp_last  <= (idx == last_idx);
            sub        <= S_SEND;
          end
          S_SEND: begin
            if (disp_ready) begin
              disp_valid <= 1'b0;
              if (disp_last) begin
                sub       <= S_DWELL;
                dwell_cnt <= 32'd0;
              end else begin
                idx     <= idx + 1'b1;
                rd_en   <= 1'b1;
                rd_addr <= idx + 1'b1;
                sub     <= S_ISSUE;
              end
            end
          end
          S_DWELL: begin
            if (dwell_done) begin
              dwell_cnt <= 32'd0;
              idx       <= '0;
              if (current_display == PH_SA2) begin
                current_display <= PH_DONE;
                sub             <= S_DONE;
              end else begin
                current_display <= current_display + 3'd1;
                sub             <= S_ISSUE;
                rd_en           <= 1'b1;
                rd_sel          <= current_display[1:0];
                rd_addr         <= '0;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 32'd1;
            end
          end
          S_DONE: sub <= S_DONE;
          default: sub <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized scoreboard bench for display_sequencer with a short dwell period.
module tb_display_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int PE     = 16;
  localparam int SA3    = 9;
  localparam int SA2    = 4;
  localparam int D      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              state_display;
  logic              next_btn;
  logic              rd_en;
  logic [1:0]        rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_last;
  logic              disp_ready;
  logic [2:0]        current_display;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         phase;
    int         addr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [0:2][0:31];
  int         tests = 0;
  int         fails = 0;
  bit         rand_ready = 1'b0;
  bit         chk_stable = 1'b1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  display_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PE_WORDS(PE), .SA3_WORDS(SA3),
    .SA2_WORDS(SA2), .DWELL_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .state_display(state_display), .next_btn(next_btn),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_last(disp_last),
    .disp_ready(disp_ready), .current_display(current_display)
  );

  always #5 clk = ~clk;

  // Result buffer: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en && rd_sel <= 2'd2) rd_data <= mem[rd_sel][rd_addr];
    else                         rd_data <= 8'($urandom);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) disp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int words_of(input int p);
    return (p == 0) ? PE : (p == 1) ? SA3 : SA2;
  endfunction

  function automatic void fill_mem(input bit pattern);
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < 32; a++)
        mem[p][a] = pattern ? 8'(a + 16 * p) : 8'($urandom);
  endfunction

  function automatic void push_stream();
    exp_t e;
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < words_of(p); a++) begin
        e.data  = mem[p][a];
        e.last  = (a == words_of(p) - 1);
        e.phase = p + 1;
        e.addr  = a;
        exp_q.push_back(e);
      end
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_stall && chk_stable)
        checkOutput("stall_hold", int'({disp_valid, disp_data, disp_last}),
                    int'({1'b1, prev_data, prev_last}));
      if (rd_en) checkOutput("rd_sel", int'(rd_sel), int'(current_display) - 1);
      if (disp_valid && disp_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("queue_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("word_data", int'(disp_data), int'(e.data));
          checkOutput("word_last", int'(disp_last), int'(e.last));
          checkOutput("word_phase", int'(current_display), e.phase);
        end
      end
    end
    prev_stall = disp_valid && !disp_ready;
    prev_data  = disp_data;
    prev_last  = disp_last;
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_cd"}, int'(current_display), 0);
    checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
    checkOutput({tag, "_rd_sel"}, int'(rd_sel), 0);
    checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
    checkOutput({tag, "_valid"}, int'(disp_valid), 0);
    checkOutput({tag, "_data"}, int'(disp_data), 0);
    checkOutput({tag, "_last"}, int'(disp_last), 0);
  endtask

  task automatic run_to_done(input string tag, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      applyStimulus(1);
      if (current_display == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_reach_done"}, int'(found), 1);
    checkOutput({tag, "_stream_complete"}, exp_q.size(), 0);
  endtask

  task automatic drop_display(input string tag);
    state_display = 1'b0;
    applyStimulus(1);
    checkOutput({tag, "_drop_idle"}, int'(current_display), 0);
  endtask

  // Advance until a freshly raised word matches phase/address (or the last word).
  task automatic wait_word(input string tag, input int phase, input int addr, input bit want_last);
    bit found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1);
      if (disp_valid && int'(current_display) == phase &&
          (want_last ? disp_last : (exp_q.size() > 0 && exp_q[0].addr == addr))) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_found"}, int'(found), 1);
  endtask

  initial begin
    int exp_time [5];
    int prev_cd;
    int bad_cd;
    int bad_rd;
    bit found;

    reset = 1'b1; state_display = 1'b0; next_btn = 1'b0; disp_ready = 1'b1;
    fill_mem(1'b1);
    applyStimulus(3);
    check_all_zero("reset");
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("idle_wait_cd", int'(current_display), 0);
    checkOutput("idle_wait_rd_en", int'(rd_en), 0);

    // Full walk with patterned buffers and ready always high.
    exp_time[2] = 3 * PE + D;
    exp_time[3] = exp_time[2] + 3 * SA3 + D;
    exp_time[4] = exp_time[3] + 3 * SA2 + D;
    push_stream();
    state_display = 1'b1;
    applyStimulus(1);
    checkOutput("e0_cd", int'(current_display), 1);
    checkOutput("e0_rd_en", int'(rd_en), 1);
    checkOutput("e0_rd_addr", int'(rd_addr), 0);
    prev_cd = 1;
    found = 1'b0;
    for (int k = 1; k < 400; k++) begin
      applyStimulus(1);
      if (k == 1) checkOutput("e1_valid", int'(disp_valid), 0);
      if (k == 2) checkOutput("e2_valid", int'(disp_valid), 1);
      if (int'(current_display) != prev_cd) begin
        checkOutput("step_value", int'(current_display), prev_cd + 1);
        if (current_display >= 3'd2 && current_display <= 3'd4)
          checkOutput($sformatf("step_time_%0d", current_display), k, exp_time[current_display]);
        prev_cd = int'(current_display);
        if (current_display == 3'd4) begin
          found = 1'b1;
          break;
        end
      end
    end
    checkOutput("walk_reach_done", int'(found), 1);
    bad_cd = 0; bad_rd = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (current_display != 3'd4) bad_cd++;
      if (rd_en) bad_rd++;
    end
    checkOutput("done_hold_cd_errors", bad_cd, 0);
    checkOutput("done_hold_rd_en_errors", bad_rd, 0);
    checkOutput("walk_stream_complete", exp_q.size(), 0);
    drop_display("walk");

    // Random buffer contents and a 50% ready duty cycle.
    fill_mem(1'b0);
    push_stream();
    rand_ready = 1'b1;
    state_display = 1'b1;
    run_to_done("random", 2000);
    rand_ready = 1'b0;
    disp_ready = 1'b1;
    drop_display("random");

    // Button in PE dwell ends it early; button during SEND is ignored.
    fill_mem(1'b0);
    push_stream();
    state_display = 1'b1;
    wait_word("btn_pe_last", 1, 0, 1'b1);
    applyStimulus(3);
    checkOutput("btn_before_rise", int'(current_display), 1);
    next_btn = 1'b1;
    applyStimulus(1);
    checkOutput("btn_advance", int'(current_display), 2);
    next_btn = 1'b0;
    wait_word("btn_sa3_first", 2, 0, 1'b0);
    disp_ready = 1'b0;
    next_btn = 1'b1;
    applyStimulus(1);
    next_btn = 1'b0;
    applyStimulus(2);
    disp_ready = 1'b1;
    wait_word("btn_sa3_last", 2, 0, 1'b1);
    applyStimulus(1);
    found = 1'b0;
    for (int k = 1; k < D + 20; k++) begin
      applyStimulus(1);
      if (current_display == 3'd3) begin
        checkOutput("sa3_dwell_len", k, D);
        found = 1'b1;
        break;
      end
    end
    checkOutput("sa3_dwell_end", int'(found), 1);
    run_to_done("btn", 500);
    drop_display("btn");

    // Abort while 3x3 word 4 is on offer, then restart from PE word 0.
    fill_mem(1'b0);
    push_stream();
    state_display = 1'b1;
    wait_word("abort_sa3_w4", 2, 4, 1'b0);
    chk_stable = 1'b0;
    state_display = 1'b0;
    disp_ready = 1'b0;
    applyStimulus(1);
    checkOutput("abort_valid", int'(disp_valid), 0);
    checkOutput("abort_last", int'(disp_last), 0);
    checkOutput("abort_cd", int'(current_display), 0);
    checkOutput("abort_rd_en", int'(rd_en), 0);
    exp_q.delete();
    disp_ready = 1'b1;
    applyStimulus(2);
    chk_stable = 1'b1;
    push_stream();
    state_display = 1'b1;
    applyStimulus(1);
    checkOutput("restart_cd", int'(current_display), 1);
    checkOutput("restart_rd_en", int'(rd_en), 1);
    checkOutput("restart_rd_addr", int'(rd_addr), 0);
    run_to_done("abort", 500);
    drop_display("abort");

    // Reset while PE word 5 is on offer; no restart until display is requested.
    fill_mem(1'b0);
    push_stream();
    state_display = 1'b1;
    wait_word("reset_pe_w5", 1, 5, 1'b0);
    chk_stable = 1'b0;
    reset = 1'b1;
    state_display = 1'b0;
    disp_ready = 1'b0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(3);
    check_all_zero("midsend_reset");
    exp_q.delete();
    disp_ready = 1'b1;
    chk_stable = 1'b1;
    fill_mem(1'b0);
    push_stream();
    state_display = 1'b1;
    applyStimulus(1);
    checkOutput("post_reset_rd_addr", int'(rd_addr), 0);
    checkOutput("post_reset_cd", int'(current_display), 1);
    run_to_done("reset", 500);
    drop_display("reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Display-side responder to the top-level pipeline controller. While `state_display` is high it walks the result phases in order: PE result, 3x3 systolic-array result, 2x2 systolic-array result, then DONE. For each phase it reads the result buffer word by word, streams the words to the display driver over a valid/ready handshake, and holds the phase for a dwell period. It reports progress on `current_display`; the controller leaves its display state when this reads 4.

## Interface
- `DATA_W`, default 8: result word width.
- `ADDR_W`, default 5: result-buffer address width.
- `PE_WORDS`, default 16: words in the PE result (phase 1).
- `SA3_WORDS`, default 9: words in the 3x3 result (phase 2).
- `SA2_WORDS`, default 4: words in the 2x2 result (phase 3).
- `DWELL_CYCLES`, default 50000000: hold time per phase after its last word; must be ≥ 1.

Ports:
- `clk`  in  1: the block's single clock.
- `reset`  in  1: synchronous, active-high.
- `state_display`  in  1: controller is in its display state.
- `next_btn`  in  1: operator advance; already debounced and synchronous to `clk`.
- `rd_en`  out  1: result-buffer read strobe.
- `rd_sel`  out  2: buffer select. 0 = PE, 1 = 3x3, 2 = 2x2.
- `rd_addr`  out  ADDR_W: read address.
- `rd_data`  in  DATA_W: read data, valid the cycle after `rd_en`.
- `disp_valid`  out  1: word available to the display driver.
- `disp_data`  out  DATA_W: word being offered.
- `disp_last`  out  1: the offered word is the last word of the phase.
- `disp_ready`  in  1: display driver accepts the word.
- `current_display`  out  3: phase code. 0 = IDLE, 1 = PE, 2 = 3x3, 3 = 2x2, 4 = DONE.

## Operation
- Reset values: `current_display` = 0, `rd_en` = 0, `rd_sel` = 0, `rd_addr` = 0, `disp_valid` = 0, `disp_data` = 0, `disp_last` = 0. Internal state: substate IDLE, dwell counter 0, button history 0.
- Phase FSM: IDLE(0) → PE(1) → SA3(2) → SA2(3) → DONE(4).
  - IDLE → PE on an edge where `state_display` = 1.
  - Each active phase advances when its dwell ends.
  - SA2's dwell end → DONE.
  - DONE holds while `state_display` = 1. It goes to IDLE on the first edge with `state_display` = 0.
- Per-phase substate FSM (phases 1-3):
  - ISSUE: `rd_en` = 1, `rd_sel` = phase − 1, `rd_addr` = word index. Lasts exactly 1 cycle, then LATCH.
  - LATCH: lasts 1 cycle. At its closing edge, `disp_data` ← `rd_data`, `disp_valid` ← 1, `disp_last` ← (index == N − 1). Then SEND.
  - SEND: hold `disp_valid`, `disp_data` and `disp_last` stable until an edge with `disp_valid` & `disp_ready`.
    - At that edge `disp_valid` ← 0.
    - If the word was not last: index + 1, go to ISSUE.
    - If it was last: go to DWELL with the counter cleared.
  - DWELL: counter increments each cycle. The dwell ends at an edge where counter == `DWELL_CYCLES` − 1 or a button rise is sampled, whichever comes first. On dwell end: phase + 1, index ← 0, substate ISSUE (or DONE after SA2).
- N is `PE_WORDS`, `SA3_WORDS` or `SA2_WORDS` for phases 1, 2, 3 respectively.
- `rd_en` is 0 in every substate except ISSUE.
- `rd_addr` and `rd_sel` keep their last values outside ISSUE.
- Button rise = `next_btn` & ~`next_btn_q`. The history register `next_btn_q` updates every cycle. A rise is acted on only in DWELL; rises in any other substate are discarded, not queued.
- Abort: if `state_display` = 0 at an edge while the phase is 1-4, the next state is phase 0, substate IDLE, `disp_valid` = 0, `disp_last` = 0, index 0, counter 0. This is the only case where `disp_valid` may drop without a handshake.
- Reset has priority over all other events, including mid-SEND and mid-DWELL.

## Timing
- Edge E0 samples `state_display` = 1 in IDLE. After E0: `current_display` = 1 and `rd_en` = 1 with address 0.
- First `disp_valid` rises after E0 + 2 edges.
- With `disp_ready` held high, each word takes 3 cycles. The phase streaming section therefore lasts 3N cycles, followed by `DWELL_CYCLES` cycles.
- `current_display` changes on the same edge that ends the dwell. The next phase's ISSUE is the first cycle of the new value.
- Stalls: each cycle of `disp_ready` = 0 in SEND adds exactly one cycle.
- Total time from E0 to `current_display` = 4, with ready always high and no button: 3·(16 + 9 + 4) + 3·`DWELL_CYCLES` cycles at default sizes.

## Test plan
Bench overrides `DWELL_CYCLES` = 8.
- Reset mid-SEND of PE word 5, then release → all outputs 0 and `current_display` = 0. Sequence restarts at PE address 0 only once `state_display` = 1 is seen again.
- `state_display` held 1, `disp_ready` = 1, buffers contain address + 0x10·sel → 16, then 9, then 4 words in order with `disp_last` on the final word of each phase. `current_display` steps 1, 2, 3, 4 at cycles 56, 91, 111 after E0. It returns to 0 one edge after `state_display` drops.
- `disp_ready` random 50% → identical word stream; `disp_valid` and `disp_data` never change while valid & ~ready.
- `next_btn` pulsed in DWELL of PE, 2 cycles after the last handshake → phase 2 starts 3 cycles after the handshake. A pulse during SEND has no effect.
- `state_display` dropped during 3x3 word 4 → `disp_valid` = 0 and `current_display` = 0 after the next edge. Re-asserting it restarts at PE word 0.
- `state_display` held high after `current_display` = 4 for 20 cycles → `current_display` stays 4 and `rd_en` stays 0.
